ad9361_rx_unpack: RTL and testbench

AD9361_RX_UNPACK -- requirements
Module: ad9361_rx_unpack

---
 rtl/ad9361_pkg.sv | 23 ++
 rtl/ad9361_rx_fifo.sv | 63 ++++++
 rtl/ad9361_rx_unpack.sv | 137 +++++++++++++
 tb/tb_ad9361_rx_unpack.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9361_pkg.sv
// Shared types and word layout for the AD9361 receive-path unpacker.
package ad9361_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } rx_state_t;

    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 48;

    // Field offsets inside the packed word {data1_q, data1_i, data0_q, data0_i}
    localparam int D0_I_LSB = 0;
    localparam int D0_Q_LSB = 12;
    localparam int D1_I_LSB = 24;
    localparam int D1_Q_LSB = 36;

    function automatic logic [SAMPLE_W-1:0] get_sample(input logic [WORD_W-1:0] word, input int lsb);
        get_sample = word[lsb +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/ad9361_rx_fifo.sv
// First-word-fall-through buffer for framed ADC words; drops on push-into-full
// unless a pop frees a slot in the same cycle.
module ad9361_rx_fifo
    import ad9361_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] head_data,
    output logic              out_valid,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              overflow_r;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              wr_en_s;

    // Occupancy decode: pointers carry an extra wrap bit to tell full from empty
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s   = out_ready && !empty_s;
        wr_en_s = push && (!full_s || pop_s);
    end

    // Storage, pointers and the registered drop pulse
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= (AW+1)'(0);
            rd_ptr_r   <= (AW+1)'(0);
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            overflow_r <= push && full_s && !pop_s;
        end
    end

    assign head_data = mem_r[rd_ptr_r[AW-1:0]];
    assign out_valid = !empty_s;
    assign overflow  = overflow_r;

endmodule

// File: rtl/ad9361_rx_unpack.sv
// AD9361 receive unpacker: frames adc_valid cadence, buffers locked words, splits I/Q.
// Optional feature macro RX_DROP_CNT_EN adds the saturating drop_cnt output.
module ad9361_rx_unpack
    import ad9361_pkg::*;
#(
    parameter int VALID_PERIOD = 4,
    parameter int LOCK_COUNT   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                adc_valid,
    input  logic [WORD_W-1:0]   adc_data,
    input  logic                adc_status,
    output logic [SAMPLE_W-1:0] adc_data0_i,
    output logic [SAMPLE_W-1:0] adc_data0_q,
    output logic [SAMPLE_W-1:0] adc_data1_i,
    output logic [SAMPLE_W-1:0] adc_data1_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                locked,
    output logic                overflow
`ifdef RX_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int GAP_W = $clog2(VALID_PERIOD + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(VALID_PERIOD);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(VALID_PERIOD - 1);
    localparam logic [3:0]       GOOD_LOCK = 4'(LOCK_COUNT);

    rx_state_t         state_r;
    logic [3:0]        good_r;
    logic [GAP_W-1:0]  gap_r;
    logic              locked_r;
    logic              on_time_s;
    logic              lose_s;
    logic              push_s;
    logic [WORD_W-1:0] head_s;

    // Cadence checks use the gap value before this cycle's update
    always_comb begin
        on_time_s = adc_valid && adc_status && (gap_r == GAP_LAST);
        lose_s    = !adc_status || (adc_valid && !on_time_s) || (gap_r == GAP_MAX);
        push_s    = on_time_s && (state_r == ST_LOCK);
    end

    // Cycles since the last strobe, saturating one past the expected spacing
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            gap_r <= {GAP_W{1'b0}};
        end else if (adc_valid) begin
            gap_r <= {GAP_W{1'b0}};
        end else if (gap_r != GAP_MAX) begin
            gap_r <= gap_r + GAP_W'(1);
        end
    end

    // Framing FSM with registered lock indication
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_UNLOCK;
            good_r   <= 4'd0;
            locked_r <= 1'b0;
        end else begin
            case (state_r)
                ST_UNLOCK: begin
                    if (adc_valid && adc_status) begin
                        state_r <= ST_ACQ;
                        good_r  <= 4'd1;
                    end
                end
                ST_ACQ: begin
                    if (lose_s) begin
                        state_r <= ST_UNLOCK;
                        good_r  <= 4'd0;
                    end else if (adc_valid) begin
                        good_r <= good_r + 4'd1;
                        if ((good_r + 4'd1) == GOOD_LOCK) begin
                            state_r  <= ST_LOCK;
                            locked_r <= 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (lose_s) begin
                        state_r  <= ST_UNLOCK;
                        good_r   <= 4'd0;
                        locked_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_UNLOCK;
                    good_r   <= 4'd0;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    ad9361_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (adc_data),
        .out_ready (out_ready),
        .head_data (head_s),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    assign adc_data0_i = get_sample(head_s, D0_I_LSB);
    assign adc_data0_q = get_sample(head_s, D0_Q_LSB);
    assign adc_data1_i = get_sample(head_s, D1_I_LSB);
    assign adc_data1_q = get_sample(head_s, D1_Q_LSB);
    assign locked      = locked_r;

`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating tally of overflow pulses
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'd0;
        end else if (overflow && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_ad9361_rx_unpack.sv
// Self-checking bench for ad9361_rx_unpack: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_ad9361_rx_unpack;

    localparam int VP    = 4;
    localparam int LC    = 8;
    localparam int DEPTH = 4;
    localparam int UNL   = 0;
    localparam int ACQ   = 1;
    localparam int LCK   = 2;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        adc_valid = 1'b0;
    logic [47:0] adc_data = 48'd0;
    logic        adc_status = 1'b1;
    logic        out_ready = 1'b0;
    logic [11:0] adc_data0_i, adc_data0_q, adc_data1_i, adc_data1_q;
    logic        out_valid, locked, overflow;
`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen = 0;

    // reference model state
    int          m_st = UNL;
    int          m_good = 0;
    int          m_gap = 0;
    bit          m_ovf = 1'b0;
    int          m_drops = 0;
    logic [47:0] q[$];
    bit          ot, lose, pop, psh;
    logic [47:0] head;

    ad9361_rx_unpack #(.VALID_PERIOD(VP), .LOCK_COUNT(LC), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .adc_status  (adc_status),
        .adc_data0_i (adc_data0_i),
        .adc_data0_q (adc_data0_q),
        .adc_data1_i (adc_data1_i),
        .adc_data1_q (adc_data1_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .locked      (locked),
        .overflow    (overflow)
`ifdef RX_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [47:0] w(input int n);
        w = 48'h000300200100 + 48'(n);
    endfunction

    // one strobe followed by sp-1 idle cycles
    task automatic send_word(input logic [47:0] d, input int sp);
        adc_valid = 1'b1;
        adc_data  = d;
        cycle();
        adc_valid = 1'b0;
        repeat (sp - 1) cycle();
    endtask

    task automatic relock(input int first);
        repeat (6) cycle();
        for (int n = 0; n < LC; n++) begin
            send_word(w(first + n), VP);
            if (n == LC - 2) chk("no_lock_before_last", locked, 1'b0);
        end
        chk("lock_after_count", locked, 1'b1);
    endtask

    task automatic drain_expect(input int n, input int first);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_order", adc_data0_i, 48'(12'h100 + 12'(first + i)));
            cycle();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 1'b0);
    endtask

    // Reference model: spec rules with a queue as the buffer
    initial begin
        forever begin
            @(posedge sys_clk);
            if (rst) begin
                m_st = UNL; m_good = 0; m_gap = 0; m_ovf = 1'b0; m_drops = 0;
                q.delete();
            end else begin
                ot   = adc_valid && adc_status && (m_gap == VP - 1);
                lose = !adc_status || (adc_valid && !ot) || (m_gap == VP);
                pop  = out_ready && (q.size() > 0);
                psh  = ot && (m_st == LCK);
                if (m_ovf && m_drops < 65535) m_drops++;
                m_ovf = 1'b0;
                if (pop) void'(q.pop_front());
                if (psh) begin
                    if (q.size() < DEPTH) q.push_back(adc_data);
                    else m_ovf = 1'b1;
                end
                if (m_st == UNL) begin
                    if (adc_valid && adc_status) begin m_st = ACQ; m_good = 1; end
                end else if (lose) begin
                    m_st = UNL; m_good = 0;
                end else if (m_st == ACQ && adc_valid) begin
                    m_good++;
                    if (m_good == LC) m_st = LCK;
                end
                if (adc_valid) m_gap = 0;
                else if (m_gap < VP) m_gap++;
            end
        end
    end

    // Compare DUT against the model away from the active edge
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (overflow === 1'b1) ovf_seen++;
                chk("locked", locked, 48'(m_st == LCK));
                chk("out_valid", out_valid, 48'(q.size() > 0));
                chk("overflow", overflow, 48'(m_ovf));
`ifdef RX_DROP_CNT_EN
                chk("drop_cnt", drop_cnt, 48'(m_drops));
`endif
                if (q.size() > 0) begin
                    head = q[0];
                    chk("data0_i", adc_data0_i, 48'(head[11:0]));
                    chk("data0_q", adc_data0_q, 48'(head[23:12]));
                    chk("data1_i", adc_data1_i, 48'(head[35:24]));
                    chk("data1_q", adc_data1_q, 48'(head[47:36]));
                end
            end
        end
    end

    initial begin
        int cnt;
        logic [63:0] r64;
        #1 rst = 1'b1;
        repeat (3) cycle();
        chk("rst_locked", locked, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_data0_i", adc_data0_i, 12'h000);
        chk("rst_data1_q", adc_data1_q, 12'h000);
`ifdef RX_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 16'd0);
`endif
        rst = 1'b0;
        cycle();

        // acquisition: lock after 8th word, 9th word is the first pushed
        out_ready = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            send_word(w(n), VP);
            if (n == 7) chk("acq_not_locked", locked, 1'b0);
        end
        chk("acq_locked", locked, 1'b1);
        adc_valid = 1'b1; adc_data = w(9);
        cycle();
        adc_valid = 1'b0;
        chk("first_push_valid", out_valid, 1'b1);
        chk("first_push_d0i", adc_data0_i, 12'h109);
        chk("first_push_d1i", adc_data1_i, 12'h300);
        repeat (3) cycle();

        // early strobe drops lock and is not buffered
        out_ready = 1'b0;
        send_word(w(10), 3);
        adc_valid = 1'b1; adc_data = w(11);
        cycle();
        adc_valid = 1'b0;
        chk("early_unlock", locked, 1'b0);
        chk("early_head", adc_data0_i, 12'h10A);
        out_ready = 1'b1;
        cycle();
        chk("early_not_pushed", out_valid, 1'b0);
        repeat (2) cycle();
        for (int n = 12; n <= 19; n++) begin
            send_word(w(n), VP);
            if (n == 18) chk("relock_pending", locked, 1'b0);
        end
        chk("relock", locked, 1'b1);

        // strobes stop: lock lost, buffered words still drain
        out_ready = 1'b0;
        for (int n = 20; n <= 22; n++) send_word(w(n), VP);
        cnt = 0;
        while (locked === 1'b1 && cnt < 6) begin cycle(); cnt++; end
        chk("stall_unlock", locked, 1'b0);
        drain_expect(3, 20);

        // five words into a depth-4 buffer with no reader
        relock(23);
        ovf_seen = 0;
        for (int n = 31; n <= 35; n++) send_word(w(n), VP);
        chk("ovf_pulses", 48'(ovf_seen), 48'd1);
`ifdef RX_DROP_CNT_EN
        chk("drop_cnt_one", drop_cnt, 16'd1);
`endif
        drain_expect(4, 31);

        // full buffer, pop coincident with push: accepted, order kept
        relock(36);
        out_ready = 1'b0;
        for (int n = 44; n <= 47; n++) send_word(w(n), VP);
        ovf_seen = 0;
        adc_valid = 1'b1; adc_data = w(48); out_ready = 1'b1;
        cycle();
        adc_valid = 1'b0; out_ready = 1'b0;
        repeat (3) cycle();
        chk("coincident_no_ovf", 48'(ovf_seen), 48'd0);
        drain_expect(4, 45);

        // reset with words buffered
        relock(49);
        for (int n = 57; n <= 59; n++) send_word(w(n), VP);
        chk("prerst_valid", out_valid, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("postrst_valid", out_valid, 1'b0);
        chk("postrst_locked", locked, 1'b0);
        cycle();
        chk("postrst_first_cycle", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_stale", out_valid, 1'b0);
        end

        // random traffic against the model
        cnt = 0;
        for (int c = 0; c < 6000; c++) begin
            if (cnt == 0) begin
                r64 = {$urandom(), $urandom()};
                adc_valid = 1'b1;
                adc_data  = r64[47:0];
                cnt = ($urandom_range(0, 19) < 17) ? VP : $urandom_range(1, 6);
            end else begin
                adc_valid = 1'b0;
            end
            cnt--;
            adc_status = ($urandom_range(0, 199) != 0);
            out_ready  = (c % 1000 < 500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            cycle();
        end
        adc_valid = 1'b0;
        adc_status = 1'b1;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
